// File: rtl/synth_audio_pkg.sv
// Audio constants shared by the synthesizer core and the I2S transmitter.
package synth_audio_pkg;

  localparam int AUDIO_W                = 16;
  localparam int I2S_SLOTS_PER_CH       = 32;
  localparam int I2S_SCLK_PER_MCLK_LOG2 = 3;

  typedef logic [AUDIO_W-1:0] sample_t;

endpackage

// File: rtl/i2s_stream_tx_if.sv
// Sample stream feeding the I2S transmitter (mixer / RAM playback -> DAC path).
// Handshake: a word moves on each rising clk with s_valid && s_ready; the source
// holds s_data while s_valid is high and s_ready low; s_ready never looks at s_valid.
interface i2s_stream_tx_if
  import synth_audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_W
);

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/sample_fifo.sv
// Small synchronous FIFO; rd_data_o is the stored head word, meaningful while !empty_o.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign full_o    = (level_q == FULL_LVL);
  assign empty_o   = (level_q == '0);
  assign level_o   = level_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // Overflow and underflow requests are ignored rather than corrupting pointers.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/i2s_stream_tx.sv
// Buffered I2S transmitter for the CS4344 PmodI2S: queues mono samples and plays
// each one on both channels, one sample per LRCK frame, MSB first.
module i2s_stream_tx
  import synth_audio_pkg::*;
#(
  parameter int DATA_W        = AUDIO_W,
  parameter int FIFO_DEPTH    = 4,
  parameter int MCLK_DIV_LOG2 = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  i2s_stream_tx_if.slave                s,
  input  logic                          mute,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underrun,
  output logic                          mclk,
  output logic                          lrck,
  output logic                          sclk,
  output logic                          sdout
);

  localparam int SLOT_LSB = MCLK_DIV_LOG2 + I2S_SCLK_PER_MCLK_LOG2;
  localparam int PW       = $clog2(I2S_SLOTS_PER_CH);
  localparam int W        = SLOT_LSB + PW + 1;
  localparam logic [PW-1:0] LAST_P = PW'(DATA_W);

  logic [W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0] held_q, held_d;
  logic [DATA_W-1:0] shifted;
  logic [PW-1:0]     p;
  logic              mclk_q, sclk_q, lrck_q, sdout_q, sdout_d;
  logic              load;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign cnt_d = cnt_q + W'(1);
  assign load  = &cnt_q;
  assign p     = cnt_q[SLOT_LSB +: PW];

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (s.s_valid && s.s_ready),
    .pop_i     (load),
    .wr_data_i (s.s_data),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign s.s_ready = !fifo_full;
  assign underrun  = load && fifo_empty;

  // Mute zeroes the next frame whether or not a sample was available.
  always_comb begin
    held_d = held_q;
    if (load) begin
      if (mute)             held_d = '0;
      else if (!fifo_empty) held_d = fifo_head;
    end
  end

  // Slot p = 1..DATA_W carries held[DATA_W-p]; the one-bit I2S delay puts the MSB at p = 1.
  always_comb begin
    sdout_d = 1'b0;
    shifted = held_q << (p - PW'(1));
    if (p != '0 && p <= LAST_P) sdout_d = shifted[DATA_W-1];
  end

  // sdout follows the current slot, so it settles one cycle after each SCLK fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      held_q  <= '0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      sdout_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      mclk_q  <= cnt_d[MCLK_DIV_LOG2-1];
      sclk_q  <= cnt_d[SLOT_LSB-1];
      lrck_q  <= cnt_d[W-1];
      sdout_q <= sdout_d;
    end
  end

  assign mclk  = mclk_q;
  assign sclk  = sclk_q;
  assign lrck  = lrck_q;
  assign sdout = sdout_q;

endmodule

// File: doc/i2s_stream_tx.md
# i2s_stream_tx

Buffered I2S transmitter for the PmodI2S (CS4344) DAC on JA. It accepts mono 16-bit samples over a valid/ready stream from the mixer / RAM playback path and queues them in a small FIFO. It generates MCLK, LRCK and SCLK from the 100 MHz system clock and serialises each sample MSB-first onto both stereo channels. It drops in where the audio sample leaves the synthesizer core and adds flow control and underrun reporting.

## Interface
Parameters:
- `DATA_W`, 16, sample width (two's complement)
- `FIFO_DEPTH`, 4, sample FIFO entries (power of two, ≥2)
- `MCLK_DIV_LOG2`, 2, MCLK = clk / 2^MCLK_DIV_LOG2 (2 → 25 MHz)

Ports:
- `clk`  in  1  100 MHz system clock; one clock domain
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `s_data`  in  DATA_W  sample to queue
- `s_valid`  in  1  `s_data` valid
- `s_ready`  out  1  FIFO can accept; equals !full
- `mute`  in  1  level; forces zero samples at frame load; FIFO is still drained
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current occupancy
- `underrun`  out  1  one-cycle pulse: frame load found FIFO empty
- `mclk`  out  1  DAC master clock (JA[0])
- `lrck`  out  1  word select, 0 = left (JA[1])
- `sclk`  out  1  serial bit clock (JA[2])
- `sdout`  out  1  serial data (JA[3])

## Operation
- Free-running frame counter `cnt`, width W = MCLK_DIV_LOG2+9; wraps at all-ones.
- Derived clocks, registered each cycle from the next `cnt` value:
  - `mclk` = cnt[MCLK_DIV_LOG2-1]
  - `sclk` = cnt[MCLK_DIV_LOG2+2]; SCLK = MCLK/8
  - `lrck` = cnt[W-1]; LRCK = SCLK/64 ≈ 48.83 kHz at defaults
- Slot index `slot` = cnt[W-1 : MCLK_DIV_LOG2+3] (0..63); per-channel position p = slot mod 32.
- I2S framing per channel:
  - p = 0: `sdout` = 0 (one-bit delay after the LRCK edge)
  - p = 1..16: `sdout` = held[16-p] (MSB first)
  - p = 17..31: `sdout` = 0
- Left and right carry the same held sample.
- Frame load occurs on the cycle where `cnt` = all-ones:
  - FIFO non-empty: pop; `held` ← `mute` ? 0 : head.
  - FIFO empty: `held` keeps its previous value (zero if `mute`); `underrun` pulses that cycle.
- Push occurs when `s_valid && s_ready`. Push and pop in the same cycle leave `fifo_level` unchanged; the pushed word enters behind the head.
- `s_ready` depends only on registered occupancy. There is no combinational path from `s_valid` to `s_ready`.
- `mute` is sampled only at frame load and never changes a frame in progress.

## Timing
- Reset values:
  - `cnt` = 0; `held` = 0; FIFO empty
  - `fifo_level` = 0; `s_ready` = 1; `underrun` = 0
  - `mclk` = `lrck` = `sclk` = `sdout` = 0
- Reset asserted mid-frame: all of the above take effect immediately and FIFO contents are discarded. Deassertion restarts the counter at 0 on the next rising `clk`.
- Transitions:
  - `sdout` changes only in the cycle after `sclk` falls.
  - `lrck` changes together with the `sclk` falling edge that begins slot 0 or slot 32.
- Latency from push into an empty FIFO to MSB on `sdout`: pop at the next frame load, then MSB at slot 1. Worst case is 2^W + 2^(MCLK_DIV_LOG2+3) + 1 cycles.
- Throughput: exactly one pop per frame of 2^W cycles (2048 at defaults).
- `fifo_level` and `s_ready` update the cycle after a push or pop.

## Structure
- Shared package `synth_audio_pkg`:
  - `AUDIO_W` = 16
  - `I2S_SLOTS_PER_CH` = 32
  - `I2S_SCLK_PER_MCLK_LOG2` = 3
  - `sample_t` typedef
- Sub-module `sample_fifo`: synchronous FIFO with `push`/`pop`/`full`/`empty`/`level`. Read data is the registered head, valid when not empty. Parameters `DATA_W`, `DEPTH`.
- Top level holds the counter, the held/shift register and the output registers.

## Test plan
- Reset check: after reset release with no input, outputs stay low until the counter runs. `mclk` period is 4 cycles, `sclk` period 32, `lrck` period 2048. `sdout` stays 0; `underrun` pulses at cycle 2047 and every 2048 cycles after.
- Framing: push 0xA5C3 once. The next left and right slots 1..16 carry 1010_0101_1100_0011 MSB first, and slots 0 and 17..31 are 0. Repeat the check with 0x8000 and 0x7FFF.
- Back-pressure: hold `s_valid` high with an incrementing value. `s_ready` drops once `fifo_level` = 4. Output frames carry consecutive values with none lost or duplicated, and no `underrun`.
- Simultaneous push and pop: level 2 with a push on the frame-load cycle leaves `fifo_level` = 2, and ordering is preserved.
- Mute and underrun: with FIFO {0x1234, 0x5678}, `mute` = 1 during the first load gives a zero frame and `fifo_level` = 1. After the FIFO empties, `underrun` pulses and the held 0x5678 repeats.
- Reset mid-frame: assert `rst_n` low at slot 9 with the FIFO holding 3 entries. Outputs go to 0 at once and `fifo_level` = 0. After release, the first frame is silent and `underrun` pulses.
